// File: rtl/regfile_write_bank.sv
// Write side and storage of the 32 x WIDTH register file with a hardwired-zero entry.
// Optional macro REGFILE_BYPASS_EN: regs shows same-cycle write-through of the
// incoming write data. Without it, regs is driven from the storage flops only.
module regfile_write_bank #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_IDX = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [4:0]                    wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [31:0][WIDTH-1:0]        regs,
  output logic [31:0]                   written,
  output logic                          wr_dropped
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam logic [AW-1:0]    ZERO_ADDR = AW'(ZERO_IDX);
  localparam logic [NREGS-1:0] ZERO_MASK = NREGS'(1) << ZERO_IDX;

  logic [NREGS-1:0]            wr_sel_c;
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            written_q, written_d;
  logic                        dropped_q, dropped_d;

  // One-hot write-enable decode, gated by wr_en so idle address bits never select an entry
  always_comb begin
    wr_sel_c = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      wr_sel_c[i] = wr_en && (wr_addr == AW'(i));
    end
  end

  // Next-state: update the selected entry, track written entries and dropped zero-register writes
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_sel_c[i]) begin
        regs_d[i] = wr_data;
      end
    end
    regs_d[ZERO_ADDR] = '0;
    written_d = written_q | (wr_sel_c & ~ZERO_MASK);
    dropped_d = wr_sel_c[ZERO_ADDR];
  end

  // Storage flops; reset wins over a write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '0;
      written_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read view with write-through of the in-flight write
  always_comb begin
    regs = regs_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_sel_c[i]) begin
        regs[i] = wr_data;
      end
    end
    regs[ZERO_ADDR] = '0;
  end
`else
  // Read view straight from storage; the zero entry is forced constant
  always_comb begin
    regs            = regs_q;
    regs[ZERO_ADDR] = '0;
  end
`endif

  assign written    = written_q;
  assign wr_dropped = dropped_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Randomized self-checking bench for regfile_write_bank against an array-based model.
module tb_regfile_write_bank;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned ZIDX  = 31;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic                   wr_en;
  logic [4:0]             wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [31:0][WIDTH-1:0] regs;
  logic [31:0]            written;
  logic                   wr_dropped;

  int checks;
  int errors;

  // Reference model state
  logic [WIDTH-1:0] mem [32];
  logic [31:0]      m_written;
  logic             m_dropped;

  regfile_write_bank #(.WIDTH(WIDTH), .ZERO_IDX(ZIDX)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .regs       (regs),
    .written    (written),
    .wr_dropped (wr_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s regs[%0d]", tag, i), regs[i], mem[i]);
    end
    check({tag, " written"}, 64'(written), 64'(m_written));
    check({tag, " wr_dropped"}, 64'(wr_dropped), 64'(m_dropped));
  endtask

  // One clock: drive inputs, check the same-cycle read view, then the post-edge state
  task automatic step(input string tag, input bit rst, input bit en,
                      input logic [4:0] addr, input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] exp_now;
    @(negedge clk);
    reset   = rst;
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    #1;
    if (en) begin
      exp_now = (BYPASS && (int'(addr) != ZIDX)) ? data : mem[addr];
      check({tag, " same_cycle"}, regs[addr], exp_now);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      m_written = '0;
      m_dropped = 1'b0;
    end else if (en && int'(addr) == ZIDX) begin
      m_dropped = 1'b1;
    end else if (en) begin
      mem[addr]       = data;
      m_written[addr] = 1'b1;
      m_dropped       = 1'b0;
    end else begin
      m_dropped = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [4:0]       ra;
    logic [WIDTH-1:0] rd;
    bit               rr, re;
    checks    = 0;
    errors    = 0;
    m_written = '0;
    m_dropped = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    step("init", 1'b1, 1'b0, 5'd0, '0);

    // Reset after a write clears everything
    step("t1_wr", 1'b0, 1'b1, 5'd5, 64'hDEAD);
    step("t1_rst", 1'b1, 1'b0, 5'bx, 'x);
    step("t1_rst", 1'b1, 1'b0, 5'bx, 'x);
    check("t1 written_zero", 64'(written), 64'h0);

    // Basic write
    step("t2", 1'b0, 1'b1, 5'd7, 64'h0123_4567_89AB_CDEF);
    check("t2 written_mask", 64'(written), 64'h0000_0080);

    // Zero register write is dropped, pulse lasts one cycle
    step("t3_wr", 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3 dropped_pulse", 64'(wr_dropped), 64'h1);
    step("t3_idle", 1'b0, 1'b0, 5'bx, 'x);
    check("t3 dropped_clear", 64'(wr_dropped), 64'h0);

    // Back-to-back writes
    step("t4_a", 1'b0, 1'b1, 5'd3, 64'd1);
    step("t4_b", 1'b0, 1'b1, 5'd3, 64'd2);
    step("t4_c", 1'b0, 1'b1, 5'd4, 64'd3);
    check("t4 x3", regs[3], 64'd2);
    check("t4 x4", regs[4], 64'd3);

    // Reset beats a simultaneous write
    step("t5", 1'b1, 1'b1, 5'd2, 64'd9);
    check("t5 x2", regs[2], 64'd0);

    // Same-cycle read with and without bypass
    step("t6_pre", 1'b0, 1'b1, 5'd10, 64'h11);
    step("t6_wr", 1'b0, 1'b1, 5'd10, 64'h55);
    check("t6 after_edge", regs[10], 64'h55);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 24) == 0);
      re = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      rd = {$urandom, $urandom};
      step("rnd", rr, re, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
